// File: rtl/hood_mode_controller.sv
// rtl/hood_mode_controller.sv - hood operating-mode sequencer (standby/menu/levels/hurricane/clean)
// Optional run-time accumulator and cleaning reminder enabled by HOOD_CLEAN_REMINDER_EN.
module hood_mode_controller #(
  parameter int unsigned CLK_PER_SEC   = 100_000_000,
  parameter int unsigned HURRICANE_SEC = 60,
  parameter int unsigned CLEAN_SEC     = 180,
  parameter int unsigned REMIND_SEC    = 36000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power_status,
  input  logic        menu_pulse,
  input  logic        l1_pulse,
  input  logic        l2_pulse,
  input  logic        l3_pulse,
  input  logic        clean_pulse,
  output logic [2:0]  mode,
  output logic [1:0]  fan_level,
  output logic [7:0]  remaining_sec,
  output logic        hurricane_used,
  output logic        clean_reminder,
  output logic [15:0] work_sec
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_STANDBY   = 3'd1,
    S_MENU      = 3'd2,
    S_LEVEL1    = 3'd3,
    S_LEVEL2    = 3'd4,
    S_HURRICANE = 3'd5,
    S_RETURN    = 3'd6,
    S_CLEAN     = 3'd7
  } state_t;

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [7:0] HUR_LOAD   = 8'(HURRICANE_SEC);
  localparam logic [7:0] CLEAN_LOAD = 8'(CLEAN_SEC);

  state_t        r_mode;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_rem;
  logic          r_hur_used;
  logic [1:0]    r_fan;

  state_t        w_mode_nxt;
  logic [7:0]    w_rem_nxt;
  logic          w_hur_nxt;
  logic          w_clean_done;
  logic [1:0]    w_fan_nxt;
  logic          w_tick;

  assign w_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode     <= S_OFF;
      r_presc    <= '0;
      r_rem      <= '0;
      r_hur_used <= 1'b0;
      r_fan      <= 2'd0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_rem      <= w_rem_nxt;
      r_hur_used <= w_hur_nxt;
      r_fan      <= w_fan_nxt;
      // Prescaler realigns on every mode change so timed states last whole seconds.
      if (!power_status || (w_mode_nxt != r_mode) || w_tick)
        r_presc <= '0;
      else
        r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_mode_nxt   = r_mode;
    w_rem_nxt    = r_rem;
    w_hur_nxt    = r_hur_used;
    w_clean_done = 1'b0;
    if (!power_status) begin
      w_mode_nxt = S_OFF;
      w_rem_nxt  = 8'd0;
      w_hur_nxt  = 1'b0;
    end else begin
      case (r_mode)
        S_OFF: w_mode_nxt = S_STANDBY;
        S_STANDBY: if (menu_pulse) w_mode_nxt = S_MENU;
        S_MENU: begin
          if (menu_pulse) begin
            w_mode_nxt = S_STANDBY;
          end else if (clean_pulse) begin
            w_mode_nxt = S_CLEAN;
            w_rem_nxt  = CLEAN_LOAD;
          end else if (l3_pulse && !r_hur_used) begin
            w_mode_nxt = S_HURRICANE;
            w_rem_nxt  = HUR_LOAD;
            w_hur_nxt  = 1'b1;
          end else if (l2_pulse) begin
            w_mode_nxt = S_LEVEL2;
          end else if (l1_pulse) begin
            w_mode_nxt = S_LEVEL1;
          end
        end
        S_LEVEL1, S_LEVEL2: begin
          if (menu_pulse)    w_mode_nxt = S_STANDBY;
          else if (l2_pulse) w_mode_nxt = S_LEVEL2;
          else if (l1_pulse) w_mode_nxt = S_LEVEL1;
        end
        S_HURRICANE: begin
          // Menu beats a coinciding expiry tick.
          if (menu_pulse) begin
            w_mode_nxt = S_RETURN;
            w_rem_nxt  = HUR_LOAD;
          end else if (w_tick) begin
            if (r_rem == 8'd1) begin
              w_mode_nxt = S_LEVEL2;
              w_rem_nxt  = 8'd0;
            end else begin
              w_rem_nxt = r_rem - 8'd1;
            end
          end
        end
        S_RETURN: begin
          if (w_tick) begin
            if (r_rem == 8'd1) begin
              w_mode_nxt = S_STANDBY;
              w_rem_nxt  = 8'd0;
            end else begin
              w_rem_nxt = r_rem - 8'd1;
            end
          end
        end
        S_CLEAN: begin
          if (w_tick) begin
            if (r_rem == 8'd1) begin
              w_mode_nxt   = S_STANDBY;
              w_rem_nxt    = 8'd0;
              w_clean_done = 1'b1;
            end else begin
              w_rem_nxt = r_rem - 8'd1;
            end
          end
        end
        default: w_mode_nxt = S_OFF;
      endcase
    end
  end

  always_comb begin
    w_fan_nxt = 2'd0;
    case (w_mode_nxt)
      S_LEVEL1:              w_fan_nxt = 2'd1;
      S_LEVEL2:              w_fan_nxt = 2'd2;
      S_HURRICANE, S_RETURN: w_fan_nxt = 2'd3;
      default:               w_fan_nxt = 2'd0;
    endcase
  end

  assign mode           = r_mode;
  assign fan_level      = r_fan;
  assign remaining_sec  = r_rem;
  assign hurricane_used = r_hur_used;

`ifdef HOOD_CLEAN_REMINDER_EN
  logic [15:0] r_work_sec;
  logic        w_run;

  assign w_run = (r_mode == S_LEVEL1) || (r_mode == S_LEVEL2) ||
                 (r_mode == S_HURRICANE) || (r_mode == S_RETURN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_work_sec <= 16'd0;
    else if (w_clean_done)
      r_work_sec <= 16'd0;
    else if (w_tick && w_run && (r_work_sec != 16'hFFFF))
      r_work_sec <= r_work_sec + 16'd1;
  end

  assign work_sec       = r_work_sec;
  assign clean_reminder = (32'(r_work_sec) >= REMIND_SEC);
`else
  assign work_sec       = 16'd0;
  assign clean_reminder = 1'b0;
`endif

endmodule

// File: tb/tb_hood_mode_controller.sv
// tb/tb_hood_mode_controller.sv - randomized bench for hood_mode_controller against an age-based model
module tb_hood_mode_controller;
  localparam int CPS  = 10;
  localparam int HSEC = 3;
  localparam int CSEC = 5;
  localparam int RSEC = 4;
`ifdef HOOD_CLEAN_REMINDER_EN
  localparam bit WORK_EN = 1'b1;
`else
  localparam bit WORK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        power_status = 1'b0;
  logic        menu_pulse = 1'b0;
  logic        l1_pulse = 1'b0;
  logic        l2_pulse = 1'b0;
  logic        l3_pulse = 1'b0;
  logic        clean_pulse = 1'b0;
  logic [2:0]  mode;
  logic [1:0]  fan_level;
  logic [7:0]  remaining_sec;
  logic        hurricane_used;
  logic        clean_reminder;
  logic [15:0] work_sec;

  int checks = 0;
  int errors = 0;
  // Model: mode, edges since entering it, its duration in seconds, hurricane flag, run seconds.
  int m_mode = 0;
  int m_age  = 0;
  int m_dur  = 0;
  int m_used = 0;
  int m_work = 0;

  hood_mode_controller #(
    .CLK_PER_SEC(CPS), .HURRICANE_SEC(HSEC), .CLEAN_SEC(CSEC), .REMIND_SEC(RSEC)
  ) dut (
    .clk(clk), .rst(rst), .power_status(power_status),
    .menu_pulse(menu_pulse), .l1_pulse(l1_pulse), .l2_pulse(l2_pulse),
    .l3_pulse(l3_pulse), .clean_pulse(clean_pulse),
    .mode(mode), .fan_level(fan_level), .remaining_sec(remaining_sec),
    .hurricane_used(hurricane_used), .clean_reminder(clean_reminder), .work_sec(work_sec)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur_of(input int md);
    if (md == 5 || md == 6) return HSEC;
    if (md == 7) return CSEC;
    return 0;
  endfunction

  function automatic int fan_of(input int md);
    case (md)
      3: return 1;
      4: return 2;
      5, 6: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_rem();
    if (dur_of(m_mode) == 0) return 0;
    return m_dur - m_age / CPS;
  endfunction

  task automatic model_edge(input bit pwr, input bit mn, input bit c1, input bit c2,
                            input bit c3, input bit cl);
    int nm;
    bit tick;
    bit expire;
    tick   = (m_age % CPS) == CPS - 1;
    expire = (dur_of(m_mode) != 0) && (m_age + 1 == m_dur * CPS);
    if (WORK_EN && tick && m_mode >= 3 && m_mode <= 6 && m_work < 65535) m_work++;
    nm = m_mode;
    if (!pwr) begin
      nm = 0;
      m_used = 0;
    end else begin
      case (m_mode)
        0: nm = 1;
        1: if (mn) nm = 2;
        2: begin
          if (mn) nm = 1;
          else if (cl) nm = 7;
          else if (c3 && m_used == 0) begin nm = 5; m_used = 1; end
          else if (c2) nm = 4;
          else if (c1) nm = 3;
        end
        3, 4: begin
          if (mn) nm = 1;
          else if (c2) nm = 4;
          else if (c1) nm = 3;
        end
        5: if (mn) nm = 6; else if (expire) nm = 4;
        6: if (expire) nm = 1;
        7: if (expire) begin nm = 1; if (WORK_EN) m_work = 0; end
        default: nm = 0;
      endcase
    end
    if (!pwr || nm != m_mode) begin
      m_age = 0;
      m_dur = dur_of(nm);
    end else begin
      m_age++;
    end
    m_mode = nm;
  endtask

  task automatic check_all();
    check_eq("mode", int'(mode), m_mode);
    check_eq("fan", int'(fan_level), fan_of(m_mode));
    check_eq("rem", int'(remaining_sec), exp_rem());
    check_eq("used", int'(hurricane_used), m_used);
    check_eq("work", int'(work_sec), m_work);
    check_eq("remind", int'(clean_reminder), (m_work >= RSEC) ? 1 : 0);
  endtask

  task automatic cycle(input bit pwr, input bit mn, input bit c1, input bit c2,
                       input bit c3, input bit cl);
    power_status = pwr;
    menu_pulse   = mn;
    l1_pulse     = c1;
    l2_pulse     = c2;
    l3_pulse     = c3;
    clean_pulse  = cl;
    @(posedge clk);
    model_edge(pwr, mn, c1, c2, c3, cl);
    @(negedge clk);
    menu_pulse  = 1'b0;
    l1_pulse    = 1'b0;
    l2_pulse    = 1'b0;
    l3_pulse    = 1'b0;
    clean_pulse = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
  endtask

  task automatic press_menu();  cycle(1, 1, 0, 0, 0, 0); endtask
  task automatic press_l1();    cycle(1, 0, 1, 0, 0, 0); endtask
  task automatic press_l2();    cycle(1, 0, 0, 1, 0, 0); endtask
  task automatic press_l3();    cycle(1, 0, 0, 0, 1, 0); endtask
  task automatic press_clean(); cycle(1, 0, 0, 0, 0, 1); endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mode"}, int'(mode), 0);
    check_eq({tag, "_fan"}, int'(fan_level), 0);
    check_eq({tag, "_rem"}, int'(remaining_sec), 0);
    check_eq({tag, "_used"}, int'(hurricane_used), 0);
    check_eq({tag, "_remind"}, int'(clean_reminder), 0);
    check_eq({tag, "_work"}, int'(work_sec), 0);
  endtask

  initial begin
    int off_cnt;
    bit pwr;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("pwr_on_standby", int'(mode), 1);
    press_menu();
    check_eq("menu_mode", int'(mode), 2);
    press_l1();
    check_eq("l1_mode", int'(mode), 3);
    check_eq("l1_fan", int'(fan_level), 1);
    press_menu();
    check_eq("l1_exit_mode", int'(mode), 1);
    check_eq("l1_exit_fan", int'(fan_level), 0);

    press_menu();
    press_l3();
    check_eq("hur_mode", int'(mode), 5);
    check_eq("hur_rem", int'(remaining_sec), HSEC);
    idle(HSEC * CPS - 1);
    check_eq("hur_last_cycle", int'(mode), 5);
    idle(1);
    check_eq("hur_expire_mode", int'(mode), 4);
    check_eq("hur_expire_fan", int'(fan_level), 2);
    press_menu();
    press_menu();
    press_l3();
    check_eq("hur_reuse_ignored", int'(mode), 2);

    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    press_menu();
    press_l3();
    idle(11);
    press_menu();
    check_eq("ret_mode", int'(mode), 6);
    check_eq("ret_rem", int'(remaining_sec), HSEC);
    check_eq("ret_fan", int'(fan_level), 3);
    idle(HSEC * CPS - 1);
    check_eq("ret_last_cycle", int'(mode), 6);
    idle(1);
    check_eq("ret_done", int'(mode), 1);

    press_menu();
    press_clean();
    idle(CSEC * CPS - 1);
    check_eq("clean_last_cycle", int'(mode), 7);
    idle(1);
    check_eq("clean_done", int'(mode), 1);
    check_eq("clean_work_zero", int'(work_sec), 0);

    press_menu();
    press_l2();
    idle(40);
    check_eq("run_work", int'(work_sec), WORK_EN ? 4 : 0);
    check_eq("run_remind", int'(clean_reminder), WORK_EN ? 1 : 0);
    press_menu();
    press_menu();
    press_clean();
    check_eq("clean2_rem", int'(remaining_sec), CSEC);
    idle(CSEC * CPS);
    check_eq("clean2_mode", int'(mode), 1);
    check_eq("clean2_work", int'(work_sec), 0);
    check_eq("clean2_remind", int'(clean_reminder), 0);

    press_menu();
    cycle(1, 0, 1, 0, 1, 1);
    check_eq("prio_clean", int'(mode), 7);
    idle(13);
    cycle(0, 0, 0, 0, 0, 0);
    check_eq("pwr_drop_mode", int'(mode), 0);
    check_eq("pwr_drop_rem", int'(remaining_sec), 0);
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("repower_mode", int'(mode), 1);
    check_eq("repower_used", int'(hurricane_used), 0);

    press_menu();
    press_l3();
    check_eq("hur2_used", int'(hurricane_used), 1);
    idle(7);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    m_mode = 0; m_age = 0; m_dur = 0; m_used = 0; m_work = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    off_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (off_cnt > 0) begin
        pwr = 1'b0;
        off_cnt--;
      end else if ($urandom_range(0, 199) == 0) begin
        pwr = 1'b0;
        off_cnt = $urandom_range(0, 3);
      end else begin
        pwr = 1'b1;
      end
      cycle(pwr, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 11) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
